// File: rtl/mac_result_drain.sv
// mac_result_drain: accumulates 16 MAC lane results across passes, then quantises
// (ReLU, round-half-up shift, int8 saturation) and streams one lane per beat.
module mac_result_drain #(
    parameter int NLANES = 16,
    parameter int IN_W   = 17,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   cap_valid_i,
    output logic                   cap_ready_o,
    input  logic [NLANES*IN_W-1:0] res_in_i,
    input  logic                   cap_first_i,
    input  logic                   cap_last_i,
    input  logic [4:0]             shift_i,
    input  logic                   relu_en_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_W-1:0]       out_data_o,
    output logic [3:0]             out_lane_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   sat_flag_o
);
    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [4:0]       SHIFT_MAX = 5'(ACC_W-1);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q [NLANES];
    logic [ACC_W-1:0]  acc_d [NLANES];
    logic [ACC_W-1:0]  ext [NLANES];
    logic [ACC_W-1:0]  add_sat [NLANES];
    logic [NLANES-1:0] ovf;
    logic [4:0]        shift_q, shift_d;
    logic              relu_q, relu_d;
    logic [3:0]        lane_q, lane_d, lane_nx;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              sat_q, sat_d;
    logic              cap_hs, last_hs, adv, load;
    logic [ACC_W-1:0]  q_in;
    logic [ACC_W:0]    q_rnd;
    logic signed [ACC_W:0] q_sum, q_r;
    logic              q_zero, q_ovf;
    logic [OUT_W-1:0]  q_out;

    // One extra bit on the add exposes overflow as a mismatch of the top two bits.
    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        logic [ACC_W:0] sum;
        assign ext[g]     = {{(ACC_W-IN_W){res_in_i[IN_W*g+IN_W-1]}}, res_in_i[IN_W*g +: IN_W]};
        assign sum        = {acc_q[g][ACC_W-1], acc_q[g]} + {ext[g][ACC_W-1], ext[g]};
        assign ovf[g]     = sum[ACC_W] ^ sum[ACC_W-1];
        assign add_sat[g] = ovf[g] ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    end

    always_comb begin
        cap_hs  = (state_q == ACCUM) && cap_valid_i;
        last_hs = cap_hs && cap_last_i;
        adv     = (state_q == DRAIN) && out_ready_i;
        lane_nx = lane_q + 4'd1;
        load    = last_hs || (adv && lane_q != 4'd15);
        for (int i = 0; i < NLANES; i++)
            acc_d[i] = !cap_hs ? acc_q[i] : cap_first_i ? ext[i] : add_sat[i];
        shift_d = last_hs ? ((shift_i > SHIFT_MAX) ? SHIFT_MAX : shift_i) : shift_q;
        relu_d  = last_hs ? relu_en_i : relu_q;
        // The beat being loaded is lane 0 of freshly captured data, or the next lane.
        q_in    = last_hs ? acc_d[0] : acc_q[lane_nx];
        q_rnd   = (shift_d == 5'd0) ? '0 : (ACC_W+1)'(1) << (shift_d - 5'd1);
        q_sum   = $signed({q_in[ACC_W-1], q_in} + q_rnd);
        q_r     = q_sum >>> shift_d;
        q_zero  = relu_d && q_in[ACC_W-1];
        q_ovf   = !q_zero && !(&q_r[ACC_W:OUT_W-1] || ~|q_r[ACC_W:OUT_W-1]);
        q_out   = q_zero ? '0 : q_ovf ? (q_r[ACC_W] ? OUT_MIN : OUT_MAX) : q_r[OUT_W-1:0];
        data_d  = load ? q_out : data_q;
        sat_d   = (sat_q && !(cap_hs && cap_first_i)) || (cap_hs && !cap_first_i && |ovf)
                  || (load && q_ovf);
        state_d = last_hs ? DRAIN : (adv && lane_q == 4'd15) ? ACCUM : state_q;
        lane_d  = last_hs ? 4'd0 : adv ? lane_nx : lane_q;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '{default: '0};
            shift_q <= '0;
            relu_q  <= 1'b0;
            lane_q  <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign cap_ready_o = (state_q == ACCUM);
    assign out_valid_o = (state_q == DRAIN);
    assign busy_o      = (state_q == DRAIN);
    assign out_lane_o  = lane_q;
    assign out_last_o  = (state_q == DRAIN) && (lane_q == 4'd15);
    assign out_data_o  = data_q;
    assign sat_flag_o  = sat_q;
endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: table vectors, hand-written corner sequences and random
// multi-pass groups checked against an arithmetic reference model.
module tb_mac_result_drain;
    localparam int NL = 16;
    localparam int IW = 17;

    logic Clk = 1'b0, reset = 1'b1;
    logic cap_valid = 1'b0, cap_first = 1'b0, cap_last = 1'b0, relu_en = 1'b0, out_ready = 1'b0;
    logic [NL*IW-1:0] res_in = '0;
    logic [4:0] shift = '0;
    logic cap_ready, out_valid, out_last, busy, sat_flag;
    logic [7:0] out_data;
    logic [3:0] out_lane;

    typedef struct {
        int v;
        int sh;
        bit relu;
        int exp;
        bit sat;
    } vec_t;

    vec_t tbl [13];
    int n_chk = 0, n_fail = 0;
    int acc_m [NL];
    int vals [NL];
    int exp_o [NL];
    bit sat_m = 1'b0;

    mac_result_drain dut (
        .Clk(Clk), .reset(reset), .cap_valid_i(cap_valid), .cap_ready_o(cap_ready),
        .res_in_i(res_in), .cap_first_i(cap_first), .cap_last_i(cap_last), .shift_i(shift),
        .relu_en_i(relu_en), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_lane_o(out_lane), .out_last_o(out_last),
        .busy_o(busy), .sat_flag_o(sat_flag)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Round half up = floor((v + d/2) / d), done with real division, then int8 clamp.
    function automatic int quant(input int v, input int sh, input bit rl, output bit s);
        longint d, num, q;
        s = 1'b0;
        if (rl && v < 0) return 0;
        d = longint'(1) << sh;
        num = v + ((sh > 0) ? d / 2 : 0);
        q = num / d;
        if (num % d != 0 && num < 0) q--;
        if (q > 127) begin s = 1'b1; return 127; end
        if (q < -128) begin s = 1'b1; return -128; end
        return int'(q);
    endfunction

    task automatic cap(input bit f, input bit l, input int sh, input bit rl);
        int n = 0;
        bit s;
        longint t;
        while (!cap_ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (n == 50) chk("cap_ready_wait", cap_ready, 1);
        for (int i = 0; i < NL; i++) res_in[i*IW +: IW] = vals[i][IW-1:0];
        cap_valid = 1'b1; cap_first = f; cap_last = l; shift = sh[4:0]; relu_en = rl;
        @(posedge Clk); #1;
        cap_valid = 1'b0;
        if (f) sat_m = 1'b0;
        for (int i = 0; i < NL; i++) begin
            t = f ? longint'(vals[i]) : longint'(acc_m[i]) + vals[i];
            if (t > 8388607) begin t = 8388607; sat_m = 1'b1; end
            if (t < -8388608) begin t = -8388608; sat_m = 1'b1; end
            acc_m[i] = int'(t);
        end
        if (l) for (int i = 0; i < NL; i++) begin
            exp_o[i] = quant(acc_m[i], (sh > 23) ? 23 : sh, rl, s);
            sat_m |= s;
        end
    endtask

    // mode 0: ready always high; 1: ready low/high alternating; 2: random ready.
    // Modes 1 and 2 also offer junk captures that must be ignored.
    task automatic drain(input int mode, input int want_cyc);
        int got = 0, cyc = 0;
        while (got < 16 && cyc < 100) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            if (mode != 0) begin
                cap_valid = 1'b1; cap_first = 1'b1; cap_last = 1'b1;
                for (int i = 0; i < NL; i++) res_in[i*IW +: IW] = IW'($urandom);
            end
            @(negedge Clk);
            chk("out_valid", out_valid, 1);
            chk("cap_ready_drain", cap_ready, 0);
            chk("busy", busy, 1);
            chk("out_lane", out_lane, got);
            chk("out_data", $signed(out_data), exp_o[got]);
            chk("out_last", out_last, int'(got == 15));
            if (out_ready) got++;
            @(posedge Clk); #1;
            cyc++;
        end
        out_ready = 1'b0; cap_valid = 1'b0;
        chk("drain_beats", got, 16);
        if (want_cyc > 0) chk("drain_cycles", cyc, want_cyc);
        @(negedge Clk);
        chk("idle_valid", out_valid, 0);
        chk("idle_cap_ready", cap_ready, 1);
        chk("sat_flag", sat_flag, sat_m);
    endtask

    initial begin
        tbl = '{'{6, 2, 0, 2, 0}, '{-6, 2, 0, -1, 0}, '{5, 2, 0, 1, 0}, '{-5, 2, 0, -1, 0},
                '{-2, 2, 0, 0, 0}, '{2, 2, 0, 1, 0}, '{127, 0, 0, 127, 0}, '{128, 0, 0, 127, 1},
                '{-128, 0, 0, -128, 0}, '{-129, 0, 0, -128, 1}, '{-1000, 3, 1, 0, 0},
                '{65535, 23, 0, 0, 0}, '{-65536, 9, 0, -128, 0}};
        for (int i = 0; i < NL; i++) acc_m[i] = 0;
        repeat (3) @(posedge Clk);
        #1 reset = 1'b0;
        @(negedge Clk);
        chk("rst_cap_ready", cap_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat_flag", sat_flag, 0);

        // last without any first: adds onto the zeroed accumulators
        for (int i = 0; i < NL; i++) vals[i] = int'($urandom_range(0, 131071)) - 65536;
        cap(0, 1, 3, 0);
        drain(0, 16);

        for (int k = 0; k < 13; k++) begin
            for (int i = 0; i < NL; i++) vals[i] = tbl[k].v;
            cap(1, 1, tbl[k].sh, tbl[k].relu);
            for (int i = 0; i < NL; i++) exp_o[i] = tbl[k].exp;
            sat_m = tbl[k].sat;
            drain(0, 16);
        end

        for (int i = 0; i < NL; i++) vals[i] = 100 * i;
        cap(1, 1, 2, 0);
        for (int i = 0; i < NL; i++) exp_o[i] = (i <= 5) ? 25 * i : 127;
        sat_m = 1'b1;
        drain(0, 16);

        for (int i = 0; i < NL; i++) vals[i] = -50;
        cap(1, 0, 0, 1); cap(0, 0, 0, 1); cap(0, 1, 0, 1);
        for (int i = 0; i < NL; i++) exp_o[i] = 0;
        sat_m = 1'b0;
        drain(0, 16);
        cap(1, 0, 0, 0); cap(0, 0, 0, 0); cap(0, 1, 0, 0);
        for (int i = 0; i < NL; i++) exp_o[i] = -128;
        sat_m = 1'b1;
        drain(0, 16);

        for (int i = 0; i < NL; i++) vals[i] = int'($urandom_range(0, 131071)) - 65536;
        cap(1, 1, 4, 0);
        drain(1, 32);
        for (int i = 0; i < NL; i++) vals[i] = 0;
        cap(0, 1, 9, 0);
        drain(0, 16);

        for (int i = 0; i < NL; i++) vals[i] = 1000;
        cap(1, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b1;
            @(negedge Clk);
            chk("rst_drain_lane", out_lane, k);
            @(posedge Clk); #1;
        end
        out_ready = 1'b0;
        @(negedge Clk);
        chk("sat_before_reset", sat_flag, 1);
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        @(negedge Clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_cap_ready", cap_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sat_flag", sat_flag, 0);
        chk("mid_rst_out_lane", out_lane, 0);
        chk("mid_rst_out_data", out_data, 0);
        for (int i = 0; i < NL; i++) acc_m[i] = 0;
        sat_m = 1'b0;
        for (int i = 0; i < NL; i++) vals[i] = int'($urandom_range(0, 131071)) - 65536;
        cap(1, 1, 1, 0);
        drain(0, 16);

        for (int i = 0; i < NL; i++) vals[i] = 0;
        cap(1, 0, 0, 0);
        for (int i = 0; i < NL; i++) vals[i] = 65535;
        repeat (200) cap(0, 0, 0, 0);
        cap(0, 1, 16, 0);
        for (int i = 0; i < NL; i++) chk("acc_clamp_exp", exp_o[i], 127);
        drain(0, 16);
        for (int i = 0; i < NL; i++) vals[i] = 0;
        cap(0, 1, 31, 0);
        drain(0, 16);
        cap(1, 0, 0, 0);
        for (int i = 0; i < NL; i++) vals[i] = -65536;
        repeat (130) cap(0, 0, 0, 0);
        cap(0, 1, 23, 0);
        drain(0, 16);

        repeat (40) begin
            int np;
            np = int'($urandom_range(1, 4));
            for (int p = 0; p < np; p++) begin
                for (int i = 0; i < NL; i++) vals[i] = int'($urandom_range(0, 131071)) - 65536;
                cap(p == 0, p == np - 1, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
            drain(2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Output stage directly downstream of the 16-lane MAC core. It captures the core's 16 signed 17-bit lane results and accumulates partial sums across input-channel passes at 24-bit width. On the final pass it applies optional ReLU, round-half-up right shift and int8 saturation. It then streams the 16 quantised lanes out one per cycle over a valid/ready handshake to the feature-map writer.

## Interface
- NLANES, 16, number of result lanes (fixed by MAC core)
- IN_W, 17, width of each incoming signed lane result
- ACC_W, 24, signed accumulator width per lane
- OUT_W, 8, signed output width
- Clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset; clock Clk
- cap_valid  input  1  res_in holds a valid set of 16 lane results
- cap_ready  output  1  block can accept a capture this cycle
- res_in  input  NLANES*IN_W  packed results; lane i at bits [IN_W*i+IN_W-1 : IN_W*i], two's complement
- cap_first  input  1  this capture starts a new accumulation (load, not add)
- cap_last  input  1  this capture completes accumulation; triggers drain
- shift  input  5  right-shift amount, sampled on the last-capture handshake
- relu_en  input  1  clamp negatives to 0, sampled on the last-capture handshake
- out_valid  output  1  out_data/out_lane/out_last valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  OUT_W  quantised signed lane value
- out_lane  output  4  lane index of out_data, 0..15
- out_last  output  1  high on the lane-15 beat
- busy  output  1  high in DRAIN
- sat_flag  output  1  sticky: set on any accumulator or output saturation; cleared by reset or by the cap_first handshake

## Operation
- FSM has two states.
  - ACCUM (reset state): cap_ready=1, out_valid=0.
  - DRAIN: cap_ready=0, out_valid=1, busy=1.
- Capture handshake is cap_valid && cap_ready. For each lane, ext = sign-extend(res_in lane) to ACC_W.
  - cap_first=1: acc[i] <= ext.
  - cap_first=0: acc[i] <= sat(acc[i] + ext), saturating to [-2^23, 2^23-1].
- On a cap_last handshake:
  - shift (values >23 treated as 23) and relu_en are latched.
  - lane counter is set to 0 and FSM goes to DRAIN.
  - cap_first and cap_last may be high together (single-pass accumulation).
- cap_valid during DRAIN is ignored. No data is lost, because cap_ready=0.
- Quantisation of lane L:
  - v = acc[L].
  - If relu_en and v<0, result = 0.
  - Otherwise r = (v + (shift>0 ? 2^(shift-1) : 0)) >>> shift. Compute at ACC_W+1 bits so the rounding add cannot wrap.
  - Output sat(r) to [-128, 127].
- Accumulator saturation or output saturation sets sat_flag.
- Drain advance happens on out_valid && out_ready:
  - lane 0..14: lane counter increments.
  - lane 15: FSM returns to ACCUM.
- Accumulators are not cleared after drain; the next group must start with cap_first.
- A cap_last handshake without any prior cap_first since reset drains the current accumulator contents. Accumulators reset to 0.

## Timing
- Reset values:
  - cap_ready=1, out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0, sat_flag=0
  - all acc=0, latched shift=0, latched relu_en=0, FSM=ACCUM.
- Capture latency: acc updated at the clock edge of the handshake.
- A cap_last handshake at edge N puts out_valid=1 with lane 0 data from edge N. cap_ready=0 from edge N.
- out_data, out_lane and out_last are registered and held stable while out_valid && !out_ready.
- With out_ready held high, the 16 beats are consecutive: drain takes 16 cycles.
- cap_ready is 1 on the cycle after the lane-15 handshake. Minimum turnaround is 17 cycles from last capture to next capture.
- reset asserted mid-DRAIN: at the next edge all outputs and state take their reset values. No further beats are emitted.

## Test plan
- Single pass, all lanes: res_in lane i = 100*i, cap_first=cap_last=1, shift=2, relu_en=0, out_ready=1.
  - Required: 16 consecutive beats, lane i = 25*i for i≤5 and 127 for i≥6.
  - out_last only on lane 15; sat_flag=1.
- Multi-pass with sign: three captures of -50 in every lane (first, mid, last).
  - relu_en=1 → all 0.
  - Repeat with relu_en=0, shift=0 → all -128, sat_flag=1.
- Rounding: single pass lane0=6, lane1=-6, lane2=5, shift=2, relu_en=0.
  - Required: out_data 2, -1, 1.
- Backpressure: out_ready alternates 1,0 during drain.
  - Required: out_data/out_lane stable on stalled cycles, 32 cycles to complete.
  - cap_ready=0 throughout; a cap_valid pulse during drain does not change any acc.
- Reset mid-drain: assert reset after the lane-5 handshake.
  - Required: next cycle out_valid=0, cap_ready=1, busy=0, sat_flag=0.
  - A subsequent single pass drains correctly from lane 0.
- Accumulator saturation: 200 non-first captures of 65535 per lane, then last with shift=16.
  - Required: acc clamps at 2^23-1, output = 127, sat_flag=1.
